// File: rtl/text_line_renderer.sv
// text_line_renderer
// Renders one scanline of the 8x8 4bpp text layer ahead of the beam into the
// back half of a double-buffered line buffer. Meanwhile the front half is
// streamed out as {color, pen} palette indices for the priority mixer.
module text_line_renderer #(
    parameter int W       = 320,
    parameter int VIS_H   = 240,
    parameter int MEM_LAT = 1
) (
    input  logic        CLK96,
    input  logic        RESET96,
    input  logic        HS,
    input  logic [8:0]  VRENDER,
    input  logic [8:0]  HDUMP,
    output logic [7:0]  TEXTSELECT_ADDR,
    input  logic [15:0] TEXTSELECT_DATA,
    output logic [7:0]  TEXTSCROLL_ADDR,
    input  logic [15:0] TEXTSCROLL_DATA,
    output logic [11:0] TEXTVRAM_ADDR,
    input  logic [15:0] TEXTVRAM_DATA,
    output logic [13:0] TEXTROM_ADDR,
    input  logic [15:0] TEXTROM_DATA,
    output logic [9:0]  TEXT_PIX,
    output logic        BUSY
);

    // One extra tile covers the partial tile exposed by a fine X scroll.
    localparam int TILES = W / 8 + 1;
    localparam int T_W   = $clog2(TILES + 1);
    localparam int LAT_W = $clog2(MEM_LAT + 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL,
        S_SCR,
        S_MAP,
        S_ROM0,
        S_ROM1,
        S_WR,
        S_CLR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q;
    logic               mem_ok;
    logic               front_q;
    logic [1:0]         valid_q;
    logic [8:0]         line_q;
    logic [8:0]         y_q;
    logic [8:0]         sx_q;
    logic [8:0]         clr_q;
    logic [T_W-1:0]     t_q;
    logic [2:0]         k_q;
    logic [5:0]         color_q;
    logic [9:0]         tile_q;
    logic [31:0]        pix_q;
    logic [9:0]         text_pix_q;

    // Bank is the address MSB: {bank, x[8:0]}.
    logic [9:0]         lbuf [0:1023];

    logic [T_W+2:0]     tk;
    logic signed [9:0]  wx;
    logic               wx_in;
    logic [5:0]         col;
    logic [4:0]         pen_sh;
    logic [3:0]         pen;
    logic               last_k;
    logic               last_t;
    logic               wr_en;
    logic [9:0]         wr_addr;
    logic [9:0]         wr_data;
    logic               unused_bits;

    // Upper halves of the select/scroll words carry nothing for this layer.
    assign unused_bits = &{1'b0, TEXTSELECT_DATA[15:9], TEXTSCROLL_DATA[15:9]};

    // A RAM read issued on entering a state is valid once the wait counter
    // reaches MEM_LAT.
    assign mem_ok = (lat_q == LAT_W'(MEM_LAT));

    // Screen x of pixel k of tile t, shifted left by the fine scroll; may go
    // negative for the first tile, so it is kept signed.
    assign tk     = {t_q, k_q};
    assign wx     = $signed(10'(tk)) - $signed({7'd0, sx_q[2:0]});
    assign wx_in  = (wx >= 10'sd0) && (wx < $signed(10'(W)));

    // Tile column wraps at 64 (X wraps at 512 pixels).
    assign col    = 6'(sx_q[8:3] + 6'(t_q));

    // Pixel 0 sits in the top nibble of the 32-bit row.
    assign pen_sh = {~k_q, 2'b00};
    assign pen    = pix_q[pen_sh +: 4];

    assign last_k = (k_q == 3'd7);
    assign last_t = (t_q == T_W'(TILES - 1));

    // State register
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a line start restarts the render from any state
    always_comb begin
        state_d = state_q;
        if (HS) begin
            state_d = S_SEL;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_SEL: begin
                    if (line_q >= 9'(VIS_H)) begin
                        state_d = S_CLR;
                    end else if (mem_ok) begin
                        state_d = S_SCR;
                    end
                end
                S_SCR:  if (mem_ok) state_d = S_MAP;
                S_MAP:  if (mem_ok) state_d = S_ROM0;
                S_ROM0: if (mem_ok) state_d = S_ROM1;
                S_ROM1: if (mem_ok) state_d = S_WR;
                S_WR: begin
                    if (last_k) begin
                        state_d = last_t ? S_DONE : S_MAP;
                    end
                end
                S_CLR:  if (clr_q == 9'(W - 1)) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: RAM addresses are a pure function of state and latched fields
    always_comb begin
        TEXTSELECT_ADDR = 8'd0;
        TEXTSCROLL_ADDR = 8'd0;
        TEXTVRAM_ADDR   = 12'd0;
        TEXTROM_ADDR    = 14'd0;
        BUSY            = (state_q != S_IDLE);
        case (state_q)
            S_SEL:   TEXTSELECT_ADDR = line_q[7:0];
            S_SCR:   TEXTSCROLL_ADDR = line_q[7:0];
            S_MAP:   TEXTVRAM_ADDR   = {y_q[8:3], col};
            S_ROM0:  TEXTROM_ADDR    = {tile_q, y_q[2:0], 1'b0};
            S_ROM1:  TEXTROM_ADDR    = {tile_q, y_q[2:0], 1'b1};
            default: ;
        endcase
    end

    // Control: bank swap and valid flags, read wait counter, loop counters
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            front_q <= 1'b0;
            valid_q <= 2'b00;
            lat_q   <= '0;
            t_q     <= '0;
            k_q     <= 3'd0;
            clr_q   <= 9'd0;
        end else begin
            if (HS) begin
                front_q          <= ~front_q;
                valid_q[front_q] <= 1'b0;
            end else if (state_q == S_DONE) begin
                valid_q[~front_q] <= 1'b1;
            end

            if (HS || (state_d != state_q)) begin
                lat_q <= '0;
            end else if (!mem_ok) begin
                lat_q <= lat_q + LAT_W'(1);
            end

            if (HS) begin
                t_q   <= '0;
                k_q   <= 3'd0;
                clr_q <= 9'd0;
            end else begin
                case (state_q)
                    S_SCR: if (mem_ok) t_q <= '0;
                    S_WR: begin
                        k_q <= k_q + 3'd1;
                        if (last_k) t_q <= t_q + T_W'(1);
                    end
                    S_CLR: clr_q <= clr_q + 9'd1;
                    default: ;
                endcase
            end
        end
    end

    // Datapath captures: line number, row/scroll, map entry and tile row pixels
    always_ff @(posedge CLK96) begin
        if (HS) begin
            line_q <= VRENDER;
        end
        if (mem_ok) begin
            case (state_q)
                S_SEL:   y_q  <= TEXTSELECT_DATA[8:0];
                S_SCR:   sx_q <= TEXTSCROLL_DATA[8:0];
                S_MAP: begin
                    color_q <= TEXTVRAM_DATA[15:10];
                    tile_q  <= TEXTVRAM_DATA[9:0];
                end
                S_ROM0:  pix_q[31:16] <= TEXTROM_DATA;
                S_ROM1:  pix_q[15:0]  <= TEXTROM_DATA;
                default: ;
            endcase
        end
    end

    // Back-bank write port: tile pixels during WR, zeros during CLR
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = {~front_q, wx[8:0]};
        wr_data = {color_q, pen};
        if (!HS && !RESET96) begin
            if (state_q == S_WR) begin
                wr_en = wx_in;
            end else if (state_q == S_CLR) begin
                wr_en   = 1'b1;
                wr_addr = {~front_q, clr_q};
                wr_data = 10'd0;
            end
        end
    end

    // Line buffer write
    always_ff @(posedge CLK96) begin
        if (wr_en) begin
            lbuf[wr_addr] <= wr_data;
        end
    end

    // Front-bank read: blank outside the visible width or when the bank is stale
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            text_pix_q <= 10'd0;
        end else if ((HDUMP >= 9'(W)) || !valid_q[front_q]) begin
            text_pix_q <= 10'd0;
        end else begin
            text_pix_q <= lbuf[{front_q, HDUMP}];
        end
    end

    assign TEXT_PIX = text_pix_q;

endmodule

// File: doc/text_line_renderer.md
Name: text_line_renderer

Overview:
- Downstream consumer of the text VRAM/DMA controller's read ports: text VRAM, text ROM, text select and text scroll.
- Renders the Batrider 8x8 4bpp text layer one scanline ahead into a double-buffered line buffer.
- Outputs a per-pixel palette index, {color, pen}, for the priority mixer, alongside GP9001 data.
- Runs on the 96 MHz domain.

Parameters:
- W, 320: visible pixels per line.
- VIS_H, 240: visible lines; lines >= VIS_H are rendered as transparent.
- MEM_LAT, 1: cycles from address driven to read data valid on every attached RAM port.

Ports:
- CLK96  in  1  sole clock.
- RESET96  in  1  synchronous, active-high reset.
- HS  in  1  one-cycle pulse at each line start. Swaps buffers and starts rendering line VRENDER.
- VRENDER  in  9  line to render into the back buffer.
- HDUMP  in  9  pixel being displayed from the front buffer.
- TEXTSELECT_ADDR  out  8  to controller.
- TEXTSELECT_DATA  in  16  [8:0] is the effective source row Y for this line.
- TEXTSCROLL_ADDR  out  8  to controller.
- TEXTSCROLL_DATA  in  16  [8:0] is the X scroll for this line.
- TEXTVRAM_ADDR  out  12  to controller.
- TEXTVRAM_DATA  in  16  [15:10] color, [9:0] tile number.
- TEXTROM_ADDR  out  14  to controller.
- TEXTROM_DATA  in  16  4 pixels, leftmost in [15:12].
- TEXT_PIX  out  10  {color[5:0], pen[3:0]}; pen 0 means transparent.
- BUSY  out  1  high while rendering.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Front bank = 0.
  - Both bank-valid flags = 0.
- Display path:
  - TEXT_PIX registered, 1-cycle latency from HDUMP.
  - TEXT_PIX = 0 when HDUMP >= W or the front bank's valid flag is 0.
  - Otherwise TEXT_PIX = front_bank[HDUMP].
- On HS:
  - Toggle front bank.
  - Clear the new back bank's valid flag.
  - Latch VRENDER[7:0] as line L.
  - Enter SEL. HS has priority over any state, so a render in progress is aborted and restarted; that bank stays invalid.
- FSM states (each RAM read waits MEM_LAT cycles before sampling data):
  - IDLE: BUSY=0.
  - SEL:
    - If VRENDER >= VIS_H, go to CLR.
    - Else drive TEXTSELECT_ADDR=L and latch Y=data[8:0].
  - SCR: drive TEXTSCROLL_ADDR=L, latch SX=data[8:0], set tile index t=0.
  - MAP:
    - col = ((SX>>3)+t) mod 64.
    - TEXTVRAM_ADDR = {Y[8:3] mod 64, col}; row wraps modulo 64.
    - Latch color and tile.
  - ROM0: TEXTROM_ADDR = {tile, Y[2:0], 1'b0}; latch pixels 0-3.
  - ROM1: TEXTROM_ADDR = {tile, Y[2:0], 1'b1}; latch pixels 4-7.
  - WR:
    - 8 cycles, k=0..7.
    - x = t*8 + k - SX[2:0], computed signed, 10-bit.
    - Write {color, pen_k} to back[x] only when 0 <= x < W.
    - After k=7: t=t+1. If t == W/8+1 (41), go to DONE; else go to MAP.
  - CLR: write 0 to back[0..W-1], 1 per cycle, then go to DONE.
  - DONE: set back bank valid=1, go to IDLE.
- Arithmetic: X wraps at 512 (tile col mod 64); Y uses 9 bits, row wraps mod 64.
- Budget: ~14 cycles/tile (MEM_LAT=1) * 41 tiles, so < 600 cycles per line.
- Line buffer: 2 x 512 x 10. Write port (back bank) and read port (front bank) are independent, with no conflict by construction.
- Reset mid-render aborts immediately; the next valid output requires a full HS-to-DONE cycle.

Test Plan:
- Reset, then HDUMP sweep -> TEXT_PIX=0 everywhere, BUSY=0.
- Setup:
  - Select[5]=0x010.
  - Scroll[5]=0.
  - VRAM[{2,0}]=0xFC03.
  - ROM tile 3 row 0 = 0x1234, 0x5678.
  - Sequence: HS with VRENDER=5, then wait for DONE, then HS.
  - Response: HDUMP 0..7 -> 0x3F1..0x3F8, each delayed 1 cycle.
- Same setup with Scroll[5]=0x003 -> HDUMP 0 = 0x3F4; HDUMP 0..4 = 0x3F4..0x3F8.
- Scroll=0x1FC (col 63 wraps to col 0) -> pixels at HDUMP 4..11 come from VRAM col 0.
- Second HS arrives 100 cycles after the first -> the aborted bank displays TEXT_PIX=0, BUSY restarts, and the next line renders correctly.
- VRENDER=240 -> CLR path; the whole displayed line is 0; BUSY high for W+~3 cycles.
